xs3_serial_rx: RTL and testbench
================================

XS3_SERIAL_RX -- requirements
Module: xs3_serial_rx

Interface
REQ-001 SHALL have ports: clk  in  1  clock, all state changes on rising edge.
REQ-002 SHALL have: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have: start  in  1  frame marker; high in the cycle that bit 0 (LSB) of an XS3 nibble is on ser_in.
REQ-004 SHALL have: ser_in  in  1  serial XS3 data, LSB first, one bit per cycle.
REQ-005 SHALL have: clear  in  1  synchronous clear of the digit accumulator.
REQ-006 SHALL have: bcd_digit  out  4  last successfully decoded BCD digit.
REQ-007 SHALL have: digit_valid  out  1  one-cycle pulse, bcd_digit newly updated.
REQ-008 SHALL have: code_err  out  1  one-cycle pulse, received code outside XS3 range.
REQ-009 SHALL have: frame_err  out  1  one-cycle pulse, frame aborted by early start.
REQ-010 SHALL have: busy  out  1  high whenever state is not IDLE.
REQ-011 SHALL have: bcd_word  out  16  packed BCD accumulator, newest digit in [3:0].
REQ-012 SHALL have: digit_cnt  out  3  digits held in bcd_word, 0..4.
REQ-013 SHALL have: word_full  out  1  high when digit_cnt == 4.
REQ-014 SHALL have: overflow  out  1  sticky; valid digit arrived while word_full.

Function
REQ-015 SHALL implement states IDLE, RX_1, RX_2, RX_3, DECODE; bit0 is captured on the edge leaving IDLE/DECODE.
REQ-016 SHALL, in IDLE with start=1, capture ser_in into shift bit 0 and go to RX_1; start=0 stays IDLE.
REQ-017 SHALL capture ser_in as bit 1, 2, 3 in RX_1, RX_2, RX_3 respectively; RX_1->RX_2->RX_3->DECODE unconditionally unless REQ-020.
REQ-018 SHALL, on the edge closing DECODE, evaluate code: 3 <= code <= 12 -> bcd_digit <= code - 3 (4-bit), digit_valid pulse; else code_err pulse, bcd_digit unchanged.
REQ-019 SHALL, in DECODE with start=1, also capture ser_in as bit 0 and go to RX_1 (back-to-back frames, 4-cycle nibble period); otherwise go to IDLE.
REQ-020 SHALL, when start=1 in RX_1..RX_3, abort the frame, pulse frame_err, capture ser_in as new bit 0, go to RX_1; no digit and no code_err for the aborted frame.
REQ-021 SHALL give latency: start in cycle T -> digit_valid/code_err high in cycle T+5, for exactly one cycle.
REQ-022 SHALL, on each valid digit with digit_cnt < 4, shift bcd_word <= {bcd_word[11:0], digit} and increment digit_cnt.
REQ-023 SHALL, on valid digit with digit_cnt == 4, leave bcd_word/digit_cnt unchanged, still pulse digit_valid, set overflow.
REQ-024 SHALL, on clear alone, set bcd_word=0, digit_cnt=0, overflow=0; clear does not affect the receive FSM.
REQ-025 SHALL, on clear coincident with a valid digit, produce bcd_word = {12'h000, digit}, digit_cnt = 1, overflow = 0.
REQ-026 SHALL never append on code_err; accumulator untouched.
REQ-027 SHALL treat unreachable state encodings as IDLE on the next edge.

Reset
REQ-028 SHALL, on rst, asynchronously force state IDLE, shift register 0, bcd_digit 0, all pulses 0, bcd_word 0, digit_cnt 0, overflow 0; busy=0.
REQ-029 SHALL discard any partial frame on rst asserted mid-reception; first frame after release requires a new start.

Verification
REQ-030 SHALL cover: start with ser_in 0,0,0,1 (code 8) -> cycle T+5 digit_valid=1, bcd_digit=5, bcd_word=16'h0005, digit_cnt=1.
REQ-031 SHALL cover: code 0000 then code 1111 -> two code_err pulses, no digit_valid, bcd_word unchanged.
REQ-032 SHALL cover: back-to-back frames for digits 1,2,3,4 (start every 4 cycles) -> bcd_word=16'h1234, word_full=1; fifth digit 9 -> bcd_digit=9, overflow=1, bcd_word still 16'h1234.
REQ-033 SHALL cover: start again in RX_2 -> frame_err pulse, new frame with code 12 completes -> bcd_digit=9.
REQ-034 SHALL cover: clear on the same edge as valid digit 7 with word_full -> bcd_word=16'h0007, digit_cnt=1, overflow=0.
REQ-035 SHALL cover: rst asserted in RX_3 -> all outputs 0 immediately, no digit_valid afterwards without a new start.

Source files
------------

// File: rtl/xs3_serial_rx.sv
// Serial excess-3 nibble receiver feeding a four-digit packed BCD accumulator.
// A nibble arrives LSB first after a start marker; its result pulses appear five cycles after start.
module xs3_serial_rx (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        ser_in,
   input  logic        clear,
   output logic [3:0]  bcd_digit,
   output logic        digit_valid,
   output logic        code_err,
   output logic        frame_err,
   output logic        busy,
   output logic [15:0] bcd_word,
   output logic [2:0]  digit_cnt,
   output logic        word_full,
   output logic        overflow
);
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RX_1   = 3'd1,
      RX_2   = 3'd2,
      RX_3   = 3'd3,
      DECODE = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  shift_q, shift_d;
   logic [3:0]  digit_q, digit_d;
   logic        valid_q, valid_d;
   logic        cerr_q, cerr_d;
   logic        ferr_q, ferr_d;
   logic [15:0] word_q, word_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        ovf_q, ovf_d;
   logic        code_ok;

   assign code_ok = (shift_q >= 4'd3) && (shift_q <= 4'd12);

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      digit_d = digit_q;
      valid_d = 1'b0;
      cerr_d  = 1'b0;
      ferr_d  = 1'b0;

      if (state_q == DECODE) begin
         if (code_ok) begin
            digit_d = shift_q - 4'd3;
            valid_d = 1'b1;
         end else begin
            cerr_d = 1'b1;
         end
      end

      case (state_q)
         IDLE:    state_d = IDLE;
         RX_1:    begin shift_d[1] = ser_in; state_d = RX_2;   end
         RX_2:    begin shift_d[2] = ser_in; state_d = RX_3;   end
         RX_3:    begin shift_d[3] = ser_in; state_d = DECODE; end
         default: state_d = IDLE;
      endcase

      // A start in any legal state begins a new frame; mid-frame it also aborts the old one.
      if (start && (state_q inside {IDLE, RX_1, RX_2, RX_3, DECODE})) begin
         ferr_d  = state_q inside {RX_1, RX_2, RX_3};
         shift_d = {3'b000, ser_in};
         state_d = RX_1;
      end

      word_d = clear ? 16'h0000 : word_q;
      cnt_d  = clear ? 3'd0 : cnt_q;
      ovf_d  = clear ? 1'b0 : ovf_q;
      if (valid_d) begin
         if (cnt_d != 3'd4) begin
            word_d = {word_d[11:0], digit_d};
            cnt_d  = cnt_d + 3'd1;
         end else begin
            ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= 4'd0;
         digit_q <= 4'd0;
         valid_q <= 1'b0;
         cerr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         word_q  <= 16'h0000;
         cnt_q   <= 3'd0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         digit_q <= digit_d;
         valid_q <= valid_d;
         cerr_q  <= cerr_d;
         ferr_q  <= ferr_d;
         word_q  <= word_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bcd_digit   = digit_q;
   assign digit_valid = valid_q;
   assign code_err    = cerr_q;
   assign frame_err   = ferr_q;
   assign busy        = (state_q != IDLE);
   assign bcd_word    = word_q;
   assign digit_cnt   = cnt_q;
   assign word_full   = (cnt_q == 3'd4);
   assign overflow    = ovf_q;
endmodule

// File: tb/tb_xs3_serial_rx.sv
// Bench for xs3_serial_rx: directed scenarios plus randomized frames against a frame-timing model.
module tb_xs3_serial_rx;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        ser_in = 1'b0;
   logic        clear = 1'b0;
   logic [3:0]  bcd_digit;
   logic        digit_valid, code_err, frame_err, busy, word_full, overflow;
   logic [15:0] bcd_word;
   logic [2:0]  digit_cnt;

   int tests = 0;
   int fails = 0;

   xs3_serial_rx dut (
      .clk(clk), .rst(rst), .start(start), .ser_in(ser_in), .clear(clear),
      .bcd_digit(bcd_digit), .digit_valid(digit_valid), .code_err(code_err),
      .frame_err(frame_err), .busy(busy), .bcd_word(bcd_word),
      .digit_cnt(digit_cnt), .word_full(word_full), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Model: a frame decodes exactly four edges after its start unless another start intervenes.
   int         since = 0;
   logic [3:0] ser_hist = 4'd0;
   logic [3:0] e_digit = 4'd0;
   logic       e_valid = 1'b0, e_cerr = 1'b0, e_ferr = 1'b0, e_ovf = 1'b0;
   logic [3:0] q[$];

   function automatic logic [15:0] pack_q();
      logic [15:0] w;
      w = 16'h0000;
      foreach (q[i]) w = {w[11:0], q[i]};
      return w;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         since    <= 0;
         ser_hist <= 4'd0;
         e_digit  <= 4'd0;
         e_valid  <= 1'b0;
         e_cerr   <= 1'b0;
         e_ferr   <= 1'b0;
         e_ovf    <= 1'b0;
         q.delete();
      end else begin
         e_valid <= 1'b0;
         e_cerr  <= 1'b0;
         e_ferr  <= 1'b0;
         if (clear) begin
            q.delete();
            e_ovf <= 1'b0;
         end
         if (since == 4) begin
            if (ser_hist >= 4'd3 && ser_hist <= 4'd12) begin
               e_valid <= 1'b1;
               e_digit <= ser_hist - 4'd3;
               if (q.size() < 4) q.push_back(ser_hist - 4'd3);
               else e_ovf <= 1'b1;
            end else begin
               e_cerr <= 1'b1;
            end
         end
         if (start && since >= 1 && since <= 3) e_ferr <= 1'b1;
         since    <= start ? 1 : ((since >= 1 && since <= 3) ? since + 1 : 0);
         ser_hist <= {ser_in, ser_hist[3:1]};
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      chk("bcd_digit",   32'(bcd_digit),   32'(e_digit));
      chk("digit_valid", 32'(digit_valid), 32'(e_valid));
      chk("code_err",    32'(code_err),    32'(e_cerr));
      chk("frame_err",   32'(frame_err),   32'(e_ferr));
      chk("busy",        32'(busy),        32'(since != 0));
      chk("bcd_word",    32'(bcd_word),    32'(pack_q()));
      chk("digit_cnt",   32'(digit_cnt),   32'(q.size()));
      chk("word_full",   32'(word_full),   32'(q.size() == 4));
      chk("overflow",    32'(overflow),    32'(e_ovf));
   end

   task automatic drive(input logic st, input logic si, input logic cl);
      start  = st;
      ser_in = si;
      clear  = cl;
      @(posedge clk);
      #2;
   endtask

   task automatic frame(input logic [3:0] c);
      drive(1'b1, c[0], 1'b0);
      drive(1'b0, c[1], 1'b0);
      drive(1'b0, c[2], 1'b0);
      drive(1'b0, c[3], 1'b0);
   endtask

   task automatic do_reset();
      #1 rst = 1'b1;
      @(posedge clk);
      #2 rst = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #2;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_word", 32'(bcd_word), 32'd0);
      chk("rst_digit", 32'(bcd_digit), 32'd0);
      rst = 1'b0;

      // Code 8 -> digit 5 at T+5, for exactly one cycle
      frame(4'd8);
      drive(1'b0, 1'b0, 1'b0);
      chk("c8_valid", 32'(digit_valid), 32'd1);
      chk("c8_digit", 32'(bcd_digit), 32'd5);
      chk("c8_word", 32'(bcd_word), 32'h0005);
      chk("c8_cnt", 32'(digit_cnt), 32'd1);
      drive(1'b0, 1'b0, 1'b1);
      chk("c8_pulse_once", 32'(digit_valid), 32'd0);
      chk("clear_word", 32'(bcd_word), 32'd0);

      // Out-of-range codes
      frame(4'd0);
      drive(1'b0, 1'b0, 1'b0);
      chk("c0_err", 32'(code_err), 32'd1);
      chk("c0_valid", 32'(digit_valid), 32'd0);
      frame(4'd15);
      drive(1'b0, 1'b0, 1'b0);
      chk("c15_err", 32'(code_err), 32'd1);
      chk("c15_word", 32'(bcd_word), 32'd0);

      // Back-to-back digits 1..4, then overflow with 9
      frame(4'd4); frame(4'd5); frame(4'd6); frame(4'd7);
      drive(1'b0, 1'b0, 1'b0);
      chk("b2b_word", 32'(bcd_word), 32'h1234);
      chk("b2b_full", 32'(word_full), 32'd1);
      frame(4'd12);
      drive(1'b0, 1'b0, 1'b0);
      chk("ovf_digit", 32'(bcd_digit), 32'd9);
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_word", 32'(bcd_word), 32'h1234);

      // Clear coincident with valid digit 7 while full
      frame(4'd10);
      drive(1'b0, 1'b0, 1'b1);
      chk("clr7_word", 32'(bcd_word), 32'h0007);
      chk("clr7_cnt", 32'(digit_cnt), 32'd1);
      chk("clr7_ovf", 32'(overflow), 32'd0);

      // Restart in RX_2, then code 12 completes
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
      chk("abort_ferr", 32'(frame_err), 32'd1);
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      chk("abort_digit", 32'(bcd_digit), 32'd9);
      chk("abort_valid", 32'(digit_valid), 32'd1);

      // Reset during RX_3
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      start = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("rstmid_busy", 32'(busy), 32'd0);
      chk("rstmid_word", 32'(bcd_word), 32'd0);
      chk("rstmid_cnt", 32'(digit_cnt), 32'd0);
      chk("rstmid_digit", 32'(bcd_digit), 32'd0);
      @(posedge clk);
      #2 rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 1'(i & 1), 1'b0);
         chk("rstmid_novalid", 32'(digit_valid), 32'd0);
      end

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         int sel;
         sel = $urandom_range(0, 99);
         if (sel == 0) begin
            do_reset();
         end else if (sel < 60) begin
            logic [3:0] c;
            c = 4'($urandom_range(0, 15));
            drive(1'b1, c[0], $urandom_range(0, 19) == 0);
            drive(1'b0, c[1], $urandom_range(0, 19) == 0);
            drive(1'b0, c[2], $urandom_range(0, 19) == 0);
            drive(1'b0, c[3], $urandom_range(0, 19) == 0);
         end else begin
            drive($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 24) == 0);
         end
      end

      drive(1'b0, 1'b0, 1'b0);
      repeat (6) drive(1'b0, 1'b0, 1'b0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
